demux_stream_1xn: RTL and testbench

- Parametrised 1-to-N stream demultiplexer with valid/ready handshake on the input and on every output channel.
- Each output has a one-entry registered holding slot, so one slow consumer does not block traffic to the others.
- Adds synchronous flush and out-of-range select detection with a saturating drop counter.
- Sits between a single producer and N independent consumers. It is the general form of the team's combinational 1x4 demux.

---
 rtl/demux_stream_1xn_if.sv | 29 ++
 rtl/demux_stream_1xn.sv | 89 ++++++++
 tb/tb_demux_stream_1xn.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/demux_stream_1xn_if.sv
// Stream bundle between one producer, the 1-to-N demux and its N consumers.
// The slave modport is the demux's view; the master modport is the environment's view.
interface demux_stream_1xn_if #(
  parameter int N_OUT  = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
);
  logic                      flush;
  logic [DATA_W-1:0]         in_data;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_valid;
  logic                      in_ready;
  logic [N_OUT*DATA_W-1:0]   out_data;
  logic [N_OUT-1:0]          out_valid;
  logic [N_OUT-1:0]          out_ready;
  logic                      sel_err;
  logic [CNT_W-1:0]          drop_cnt;

  modport master (
    output flush, in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel_err, drop_cnt
  );

  modport slave (
    input  flush, in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel_err, drop_cnt
  );
endinterface

// File: rtl/demux_stream_1xn.sv
// 1-to-N valid/ready stream demux with a one-entry holding slot per output,
// synchronous flush and out-of-range select dropping with a saturating counter.
module demux_stream_1xn #(
  parameter int N_OUT  = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  demux_stream_1xn_if.slave   bus
);

  logic [N_OUT-1:0]        valid_r;
  logic [N_OUT*DATA_W-1:0] data_r;
  logic                    sel_err_r;
  logic [CNT_W-1:0]        drop_cnt_r;

  logic [N_OUT-1:0]        hit_s;
  logic [N_OUT-1:0]        drain_s;
  logic [N_OUT-1:0]        load_s;
  logic                    sel_ok_s;
  logic                    slot_free_s;
  logic                    in_ready_s;
  logic                    accept_s;
  logic                    drop_s;

  // Decode select, decide acceptance; a slot being drained this cycle can take a new beat.
  always_comb begin
    hit_s = '0;
    for (int k = 0; k < N_OUT; k++) begin
      hit_s[k] = (bus.in_sel == SEL_W'(k));
    end
    drain_s     = valid_r & bus.out_ready;
    sel_ok_s    = |hit_s;
    slot_free_s = |(hit_s & (~valid_r | bus.out_ready));
    in_ready_s  = ~bus.flush & (sel_ok_s ? slot_free_s : 1'b1);
    accept_s    = bus.in_valid & in_ready_s;
    load_s      = hit_s & {N_OUT{accept_s}};
    drop_s      = accept_s & ~sel_ok_s;
  end

  // Per-channel slot occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
    end else if (bus.flush) begin
      valid_r <= '0;
    end else begin
      valid_r <= (valid_r & ~drain_s) | load_s;
    end
  end

  // Per-channel payload; flush leaves stale data in place since valid already hides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= '0;
    end else if (!bus.flush) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (load_s[k]) begin
          data_r[k*DATA_W +: DATA_W] <= bus.in_data;
        end
      end
    end
  end

  // Drop reporting: single-cycle error pulse and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_r  <= 1'b0;
      drop_cnt_r <= '0;
    end else if (bus.flush) begin
      sel_err_r  <= 1'b0;
      drop_cnt_r <= '0;
    end else begin
      sel_err_r <= drop_s;
      if (drop_s && (drop_cnt_r != {CNT_W{1'b1}})) begin
        drop_cnt_r <= drop_cnt_r + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = valid_r;
  assign bus.out_data  = data_r;
  assign bus.sel_err   = sel_err_r;
  assign bus.drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Randomised plus directed bench for demux_stream_1xn: a 4-channel instance (no
// out-of-range selects possible) and a 3-channel instance with a 2-bit drop counter.
module tb_demux_stream_1xn;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_stream_1xn_if #(.N_OUT(4), .DATA_W(8), .SEL_W(2), .CNT_W(8)) bus4 ();
  demux_stream_1xn_if #(.N_OUT(3), .DATA_W(8), .SEL_W(2), .CNT_W(2)) bus3 ();

  demux_stream_1xn #(.N_OUT(4), .DATA_W(8), .SEL_W(2), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave));
  demux_stream_1xn #(.N_OUT(3), .DATA_W(8), .SEL_W(2), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: index 0 is the 4-channel instance, index 1 the 3-channel one.
  logic       m_full [2][4];
  logic [7:0] m_data [2][4];
  int         m_cnt  [2];
  logic       m_err  [2];

  function automatic int n_out_of(input int w);
    return (w == 0) ? 4 : 3;
  endfunction

  function automatic int cnt_max_of(input int w);
    return (w == 0) ? 255 : 3;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 4; k++) begin
        m_full[w][k] = 1'b0;
        m_data[w][k] = 8'h00;
      end
      m_cnt[w] = 0;
      m_err[w] = 1'b0;
    end
  endtask

  task automatic idle_all();
    bus4.in_valid = 1'b0; bus4.flush = 1'b0; bus4.out_ready = 4'b0000;
    bus4.in_sel = 2'd0;   bus4.in_data = 8'h00;
    bus3.in_valid = 1'b0; bus3.flush = 1'b0; bus3.out_ready = 3'b000;
    bus3.in_sel = 2'd0;   bus3.in_data = 8'h00;
  endtask

  task automatic read_dut(input int w, output logic rdy, output logic [3:0] vld,
                          output logic [31:0] dat, output logic err, output logic [7:0] cnt);
    if (w == 0) begin
      rdy = bus4.in_ready; vld = bus4.out_valid; dat = bus4.out_data;
      err = bus4.sel_err;  cnt = bus4.drop_cnt;
    end else begin
      rdy = bus3.in_ready; vld = {1'b0, bus3.out_valid}; dat = {8'h00, bus3.out_data};
      err = bus3.sel_err;  cnt = {6'b0, bus3.drop_cnt};
    end
  endtask

  task automatic check_outputs(input int w, input string tag);
    logic rdy, err; logic [3:0] vld; logic [31:0] dat; logic [7:0] cnt;
    logic [3:0] exp_vld;
    read_dut(w, rdy, vld, dat, err, cnt);
    exp_vld = 4'b0000;
    for (int k = 0; k < n_out_of(w); k++) exp_vld[k] = m_full[w][k];
    check_eq({tag, ".out_valid"}, vld, exp_vld);
    for (int k = 0; k < n_out_of(w); k++) begin
      if (m_full[w][k]) check_eq($sformatf("%s.out_data[%0d]", tag, k), dat[k*8 +: 8], m_data[w][k]);
    end
    check_eq({tag, ".sel_err"}, err, m_err[w]);
    check_eq({tag, ".drop_cnt"}, cnt, 8'(m_cnt[w]));
  endtask

  // One clock of traffic on instance w; the other instance is kept frozen.
  task automatic cycle(input int w, input logic v, input logic [1:0] sel, input logic [7:0] d,
                       input logic [3:0] rdy_in, input logic fl, input string tag);
    logic rdy, err, exp_rdy, acc; logic [3:0] vld; logic [31:0] dat; logic [7:0] cnt;
    @(negedge clk);
    idle_all();
    if (w == 0) begin
      bus4.in_valid = v; bus4.in_sel = sel; bus4.in_data = d;
      bus4.out_ready = rdy_in; bus4.flush = fl;
    end else begin
      bus3.in_valid = v; bus3.in_sel = sel; bus3.in_data = d;
      bus3.out_ready = rdy_in[2:0]; bus3.flush = fl;
    end
    #1;
    if (fl) exp_rdy = 1'b0;
    else if (int'(sel) < n_out_of(w)) exp_rdy = !m_full[w][sel] || rdy_in[sel];
    else exp_rdy = 1'b1;
    read_dut(w, rdy, vld, dat, err, cnt);
    check_eq({tag, ".in_ready"}, rdy, exp_rdy);
    @(posedge clk);
    acc = v && exp_rdy;
    for (int k = 0; k < n_out_of(w); k++) if (m_full[w][k] && rdy_in[k]) m_full[w][k] = 1'b0;
    m_err[w] = 1'b0;
    if (acc) begin
      if (int'(sel) < n_out_of(w)) begin
        m_full[w][sel] = 1'b1;
        m_data[w][sel] = d;
      end else begin
        m_err[w] = 1'b1;
        if (m_cnt[w] < cnt_max_of(w)) m_cnt[w]++;
      end
    end
    if (fl) begin
      for (int k = 0; k < 4; k++) m_full[w][k] = 1'b0;
      m_cnt[w] = 0;
    end
    #1;
    check_outputs(w, tag);
  endtask

  initial begin
    logic rdy, err; logic [3:0] vld; logic [31:0] dat; logic [7:0] cnt;
    idle_all();
    model_reset();
    rst = 1'b1;
    #12;
    for (int w = 0; w < 2; w++) begin
      read_dut(w, rdy, vld, dat, err, cnt);
      check_eq("reset.out_valid", vld, 4'b0000);
      check_eq("reset.out_data", dat, 32'h0);
      check_eq("reset.sel_err", err, 1'b0);
      check_eq("reset.drop_cnt", cnt, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;

    // Routing and latency, full throughput.
    cycle(0, 1'b1, 2'd0, 8'hA1, 4'b1111, 1'b0, "route0");
    cycle(0, 1'b1, 2'd1, 8'hB2, 4'b1111, 1'b0, "route1");
    cycle(0, 1'b1, 2'd2, 8'hC3, 4'b1111, 1'b0, "route2");
    cycle(0, 1'b1, 2'd3, 8'hD4, 4'b1111, 1'b0, "route3");
    cycle(0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, "route_idle");

    // Backpressure isolation on channel 1.
    cycle(0, 1'b1, 2'd1, 8'h11, 4'b1101, 1'b0, "bp_a");
    cycle(0, 1'b1, 2'd1, 8'h22, 4'b1101, 1'b0, "bp_blocked");
    cycle(0, 1'b1, 2'd3, 8'h33, 4'b1101, 1'b0, "bp_other");
    cycle(0, 1'b1, 2'd1, 8'h22, 4'b1111, 1'b0, "bp_release");
    cycle(0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, "bp_drain");

    // Simultaneous accept and drain on channel 2.
    cycle(0, 1'b1, 2'd2, 8'h5A, 4'b0000, 1'b0, "same_fill");
    cycle(0, 1'b1, 2'd2, 8'h6B, 4'b0100, 1'b0, "same_swap");
    check_eq("same_swap.data_direct", bus4.out_data[23:16], 8'h6B);
    cycle(0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, "same_drain");

    // Out-of-range select on the 3-channel instance: counter saturates at 3.
    for (int i = 0; i < 5; i++) cycle(1, 1'b1, 2'd3, 8'(i), 4'b0000, 1'b0, "oor");
    check_eq("oor.cnt_sat", bus3.drop_cnt, 2'd3);
    cycle(1, 1'b0, 2'd3, 8'h00, 4'b0000, 1'b0, "oor_quiet");

    // Flush with a beat presented: channels 0/1 full, drop_cnt = 2 beforehand.
    cycle(1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, "pre_flush");
    cycle(1, 1'b1, 2'd0, 8'h40, 4'b0000, 1'b0, "fl_fill0");
    cycle(1, 1'b1, 2'd1, 8'h41, 4'b0000, 1'b0, "fl_fill1");
    cycle(1, 1'b1, 2'd3, 8'h42, 4'b0000, 1'b0, "fl_drop1");
    cycle(1, 1'b1, 2'd3, 8'h43, 4'b0000, 1'b0, "fl_drop2");
    check_eq("fl.cnt_before", bus3.drop_cnt, 2'd2);
    cycle(1, 1'b1, 2'd2, 8'h44, 4'b0000, 1'b1, "flush");
    cycle(1, 1'b0, 2'd2, 8'h00, 4'b0000, 1'b0, "post_flush");

    // Asynchronous reset mid-traffic: channels 0 and 2 full, one drop recorded.
    cycle(0, 1'b1, 2'd0, 8'h70, 4'b0000, 1'b0, "rst_fill0");
    cycle(0, 1'b1, 2'd2, 8'h72, 4'b0000, 1'b0, "rst_fill2");
    cycle(1, 1'b1, 2'd3, 8'h73, 4'b0000, 1'b0, "rst_drop");
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst.out_valid4", bus4.out_valid, 4'b0000);
    check_eq("async_rst.drop_cnt3", bus3.drop_cnt, 2'd0);
    check_eq("async_rst.sel_err3", bus3.sel_err, 1'b0);
    idle_all();
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomised traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      cycle(i % 2, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
            4'($urandom), 1'($urandom_range(0, 24) == 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
